// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execution unit driven by the 4-bit ALU control code.
// Most operations finish in one cycle. MUL runs a WIDTH-iteration shift-add
// multiplier, and busy stays high while it runs. Every result is registered
// and announced with a one-cycle done pulse.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  // Operation codes produced by the ALU control decoder.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  // The iteration counter only has to reach WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_MULT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             overflow_q;
  logic             done_q;

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             a_lt_b;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] acc_d;
  logic             last_iter;

  // Single-cycle datapath: result and signed-overflow flag for the live operands.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave
    // it unassigned and infer a latch.
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = a + b;
    diff    = a - b;
    a_lt_b  = sign ? ($signed(a) < $signed(b)) : (a < b);
    case (alucontrol)
      OP_ADD: begin
        alu_res = sum;
        // The sum overflows when both operands share a sign that the sum lacks.
        alu_ovf = sign & (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        // The difference overflows when the operand signs differ and the
        // result takes the sign of b.
        alu_ovf = sign & (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, a_lt_b};
      OP_SLL:  alu_res = b << shamt;
      default: alu_res = '0;   // unknown codes, and MUL, which never uses this path
    endcase
  end

  // One shift-add step: conditionally add the multiplicand, and flag the final step.
  always_comb begin
    acc_d     = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    last_iter = (count_q == CNT_W'(WIDTH - 1));
  end

  // Control FSM with registered result, flags and done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the multiplier working registers are cleared along with the
      // outputs, so an aborted multiply leaves no residue.
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b1;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register here take its value
      // from the state before the edge, independent of statement order.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (alucontrol == OP_MUL) begin
              mcand_q  <= a;
              mplier_q <= b;
              acc_q    <= '0;
              count_q  <= '0;
              state_q  <= S_MULT;
            end else begin
              result_q   <= alu_res;
              zero_q     <= (alu_res == '0);
              overflow_q <= alu_ovf;
              done_q     <= 1'b1;
            end
          end
        end
        S_MULT: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + 1'b1;
          if (last_iter) begin
            result_q   <= acc_d;
            zero_q     <= (acc_d == '0);
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy     = (state_q == S_MULT);
  assign done     = done_q;
  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Randomised and directed stimulus for alu_exec_unit, checked against a
// transaction-level reference model that is compared on every clock cycle.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1111;

  logic              clk        = 1'b0;
  logic              reset_n    = 1'b0;
  logic              start      = 1'b0;
  logic [3:0]        alucontrol = 4'b0000;
  logic              sign       = 1'b0;
  logic [WIDTH-1:0]  a          = '0;
  logic [WIDTH-1:0]  b          = '0;
  logic [4:0]        shamt      = 5'd0;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              zero;
  logic              overflow;

  int n_vec  = 0;
  int n_fail = 0;

  alu_exec_unit #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .alucontrol (alucontrol),
    .sign       (sign),
    .a          (a),
    .b          (b),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result, derived straight from the operation definitions.
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic s,
                                          input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] sh);
    longint      sx;
    longint      sy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = {32'd0, x} * {32'd0, y};
    case (op)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_NOR:  return ~(x | y);
      OP_SLT:  return s ? ((sx < sy) ? 32'd1 : 32'd0) : ((x < y) ? 32'd1 : 32'd0);
      OP_SLL:  return y << sh;
      OP_MUL:  return p[31:0];
      default: return 32'd0;
    endcase
  endfunction

  // Signed overflow: the exact sum or difference does not fit in 32 signed bits.
  function automatic logic ref_ovf(input logic [3:0] op, input logic s,
                                   input logic [31:0] x, input logic [31:0] y);
    longint      exact;
    logic [31:0] trunc;
    if (!s) return 1'b0;
    case (op)
      OP_ADD: begin
        exact = longint'($signed(x)) + longint'($signed(y));
        trunc = x + y;
        return exact != longint'($signed(trunc));
      end
      OP_SUB: begin
        exact = longint'($signed(x)) - longint'($signed(y));
        trunc = x - y;
        return exact != longint'($signed(trunc));
      end
      default: return 1'b0;
    endcase
  endfunction

  // Transaction model: how many cycles of multiply remain, and the expected output state.
  int          mul_left = 0;
  logic [31:0] mul_res  = '0;
  logic        exp_done = 1'b0;
  logic [31:0] exp_res  = '0;
  logic        exp_zero = 1'b1;
  logic        exp_ovf  = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mul_left <= 0;
      exp_done <= 1'b0;
      exp_res  <= '0;
      exp_zero <= 1'b1;
      exp_ovf  <= 1'b0;
    end else begin
      exp_done <= 1'b0;
      if (mul_left > 0) begin
        mul_left <= mul_left - 1;
        if (mul_left == 1) begin
          exp_done <= 1'b1;
          exp_res  <= mul_res;
          exp_zero <= (mul_res == 32'd0);
          exp_ovf  <= 1'b0;
        end
      end else if (start) begin
        if (alucontrol == OP_MUL) begin
          mul_left <= WIDTH;
          mul_res  <= ref_res(alucontrol, sign, a, b, shamt);
        end else begin
          exp_done <= 1'b1;
          exp_res  <= ref_res(alucontrol, sign, a, b, shamt);
          exp_zero <= (ref_res(alucontrol, sign, a, b, shamt) == 32'd0);
          exp_ovf  <= ref_ovf(alucontrol, sign, a, b);
        end
      end
    end
  end

  // Compare every output against the model on each falling edge outside reset.
  always @(negedge clk) begin
    if (reset_n) begin
      check("busy",     busy,     mul_left > 0);
      check("done",     done,     exp_done);
      check("result",   result,   exp_res);
      check("zero",     zero,     exp_zero);
      check("overflow", overflow, exp_ovf);
    end
  end

  // Call at a falling edge: present one request and return one falling edge later.
  task automatic issue(input logic [3:0] op, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] sh);
    alucontrol = op;
    sign       = s;
    a          = x;
    b          = y;
    shamt      = sh;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  // Wait, with a cycle budget, until done is seen; lat counts falling edges since the accept.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat         = 1;
    busy_cycles = 0;
    while (!done && lat < 64) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      lat++;
    end
    check("done_within_budget", done, 1'b1);
  endtask

  task automatic run_single(input string name, input logic [3:0] op, input logic s,
                            input logic [31:0] x, input logic [31:0] y, input logic [4:0] sh,
                            input logic [31:0] want_res, input logic want_ovf);
    int lat;
    int bc;
    issue(op, s, x, y, sh);
    wait_done(lat, bc);
    check({name, "_latency"}, lat, 1);
    check({name, "_result"}, result, want_res);
    check({name, "_zero"}, zero, want_res == 32'd0);
    check({name, "_overflow"}, overflow, want_ovf);
  endtask

  logic [3:0] op_tbl [9] = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOR, OP_SLT, OP_SLL, OP_MUL, 4'b1010};

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int bc;

    // Reset values while reset is held.
    repeat (2) @(negedge clk);
    check("rst_busy",     busy,     1'b0);
    check("rst_done",     done,     1'b0);
    check("rst_result",   result,   32'd0);
    check("rst_zero",     zero,     1'b1);
    check("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Add/subtract and overflow.
    run_single("add_ovf_signed",   OP_ADD, 1'b1, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1);
    run_single("add_ovf_unsigned", OP_ADD, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b0);
    run_single("sub_zero",         OP_SUB, 1'b1, 32'd5, 32'd5, 5'd0, 32'd0, 1'b0);
    run_single("sub_ovf",          OP_SUB, 1'b1, 32'h8000_0000, 32'd1, 5'd0, 32'h7FFF_FFFF, 1'b1);

    // Logic, shift, set-less-than.
    run_single("and",          OP_AND, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0);
    run_single("or",           OP_OR,  1'b0, 32'h0000_F0F0, 32'h0000_0F0F, 5'd0, 32'h0000_FFFF, 1'b0);
    run_single("nor",          OP_NOR, 1'b0, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    run_single("sll31",        OP_SLL, 1'b0, 32'd0, 32'd1, 5'd31, 32'h8000_0000, 1'b0);
    run_single("slt_signed",   OP_SLT, 1'b1, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0);
    run_single("slt_unsigned", OP_SLT, 1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b0);

    // Multiply timing and wrap-around.
    issue(OP_MUL, 1'b0, 32'h0001_2345, 32'h0000_0100, 5'd0);
    wait_done(lat, bc);
    check("mul_latency", lat, 33);
    check("mul_busy_cycles", bc, 32);
    check("mul_result", result, 32'h0123_4500);
    check("mul_busy_at_done", busy, 1'b0);
    issue(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    wait_done(lat, bc);
    check("mul_wrap_result", result, 32'h0000_0001);
    check("mul_wrap_overflow", overflow, 1'b0);

    // A start during the multiply is ignored; a start in the done cycle is taken.
    issue(OP_MUL, 1'b0, 32'd3, 32'd4, 5'd0);
    repeat (4) @(negedge clk);
    issue(OP_ADD, 1'b0, 32'd2, 32'd3, 5'd0);
    a = 32'hDEAD_BEEF;
    b = 32'h1234_5678;
    wait_done(lat, bc);
    check("mul_ignores_start", result, 32'd12);
    issue(OP_ADD, 1'b0, 32'd2, 32'd3, 5'd0);
    check("start_in_done_cycle_done", done, 1'b1);
    check("start_in_done_cycle_result", result, 32'd5);

    // Unknown code.
    run_single("illegal_1010", 4'b1010, 1'b1, 32'd5, 32'd9, 5'd3, 32'd0, 1'b0);

    // Reset in the middle of a multiply.
    issue(OP_MUL, 1'b0, 32'd5, 32'd7, 5'd0);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_busy",     busy,     1'b0);
    check("abort_done",     done,     1'b0);
    check("abort_result",   result,   32'd0);
    check("abort_zero",     zero,     1'b1);
    check("abort_overflow", overflow, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("abort_no_done", done, 1'b0);
    end
    run_single("post_abort_add", OP_ADD, 1'b0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0);

    // Random traffic; operands keep changing while a multiply runs.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) != 0);
      alucontrol = op_tbl[$urandom_range(0, 8)];
      if (alucontrol == OP_MUL && $urandom_range(0, 2) != 0) alucontrol = OP_ADD;
      if ($urandom_range(0, 15) == 0) alucontrol = 4'($urandom);
      sign  = 1'($urandom);
      a     = rand_operand();
      b     = rand_operand();
      shamt = 5'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder. Given operands and an `alucontrol` code, it performs the operation and returns a registered result with a start/done handshake. Single-cycle codes complete in one cycle. `ALU_MUL` runs a 32-iteration shift-add multiplier, and the datapath stalls on `busy` while it runs. It sits between the register-file read stage and write-back in the multi-cycle datapath.

## Interface
- `WIDTH`, 32, operand/result width; `MUL` iteration count equals `WIDTH`.
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request strobe; accepted only when `busy`=0.
- `alucontrol`  in  4  operation code, sampled on accept.
- `sign`  in  1  1 = signed semantics (overflow, SLT); sampled on accept.
- `a`  in  WIDTH  operand A (rs); sampled on accept.
- `b`  in  WIDTH  operand B (rt/immediate); sampled on accept.
- `shamt`  in  5  shift amount for `SLL`; sampled on accept.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse, result valid.
- `result`  out  WIDTH  registered result; holds until the next `done`.
- `zero`  out  1  `result`==0; registered with `result`.
- `overflow`  out  1  signed overflow of ADD/SUB; registered with `result`.

## Operation
- Codes:
  - `0010` ADD: a+b.
  - `0110` SUB: a-b.
  - `0000` AND.
  - `0001` OR.
  - `1100` NOR: ~(a|b).
  - `0111` SLT: 1 if a<b, else 0. Signed compare if `sign`=1, unsigned if `sign`=0.
  - `0011` SLL: b << shamt, zero fill.
  - `1111` MUL: low `WIDTH` bits of a*b.
  - Any other code: result 0, `overflow` 0, normal single-cycle completion.
- `overflow`:
  - ADD: set when `sign`=1 and a[MSB]==b[MSB]!=sum[MSB].
  - SUB: set when `sign`=1 and a[MSB]!=b[MSB] and diff[MSB]!=a[MSB].
  - Always 0 for other codes and when `sign`=0.
- State machine:
  - IDLE: on `start` with a single-cycle code, register `result`/`zero`/`overflow`, assert `done` next cycle, stay IDLE.
  - IDLE: on `start` with `MUL`, load mcand=a, mplier=b, acc=0, count=0, go to MULT.
  - MULT, per cycle: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, count++.
  - MULT: after the iteration with count==WIDTH-1, register result=acc (plus the final add), `zero`, `overflow`=0, go to IDLE, pulse `done`.
- `busy` = (state==MULT).
- `start` while `busy`=1 is ignored; no queuing.
- `start` in the same cycle as `done` is accepted, because the state is already IDLE.
- Inputs are only sampled on accept; changes to `a`/`b` during MULT have no effect.

## Timing
- Reset (async assert, sync release):
  - state=IDLE.
  - `busy`=0, `done`=0, `result`=0, `zero`=1, `overflow`=0.
  - Internal mcand/mplier/acc/count cleared.
- Reset asserted mid-MULT aborts the multiply immediately. No `done` is produced.
- Single-cycle op accepted at edge t: `done`=1 and `result` valid in cycle t+1; `done`=0 at t+2 unless re-triggered.
- Back-to-back single-cycle ops: `done` is high in consecutive cycles, one result each.
- MUL accepted at edge t:
  - `busy`=1 for cycles t+1 … t+WIDTH.
  - `done`=1 and `busy`=0 in cycle t+WIDTH+1, which is 33 cycles for WIDTH=32.
- `result` is stable between `done` pulses, including the entire MULT period, where it shows the previous result.

## Test plan
- Reset mid-MULT: start MUL, 5×7, assert `reset_n`=0 at cycle 10 → all outputs at reset values immediately, no `done`. After release, ADD 1+1 → `result`=2.
- ADD/SUB overflow:
  - ADD 0x7FFFFFFF+1, `sign`=1 → `result`=0x80000000, `overflow`=1, `done` at t+1.
  - Same with `sign`=0 → `overflow`=0.
  - SUB 5-5 → `result`=0, `zero`=1.
- Logic/shift/SLT:
  - AND 0xF0F0&0xFF00 → 0xF000.
  - NOR 0,0 → 0xFFFFFFFF.
  - SLL b=1, shamt=31 → 0x80000000.
  - SLT a=0xFFFFFFFF, b=1: `sign`=1 → 1; `sign`=0 → 0.
- MUL timing: 0x00012345×0x00000100 → `result`=0x01234500. `busy` high exactly 32 cycles, `done` at t+33.
- MUL wrap: 0xFFFFFFFF×0xFFFFFFFF → `result`=0x00000001, `overflow`=0.
- Handshake:
  - `start` ADD during MULT is ignored; the MUL result is unchanged.
  - `start` ADD 2+3 in the `done` cycle of MUL → `result`=5 one cycle later.
  - Illegal code `1010` → `result`=0, `zero`=1, `done` at t+1.
